hack_screen_scanner: RTL

//  Reader side of the Hack screen memory: the CPU writes 16-bit words into screen RAM, this block

---
 rtl/hack_screen_pkg.sv | 20 ++
 rtl/pixel_shifter16.sv | 29 ++
 rtl/hack_screen_scanner.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hack_screen_pkg.sv
// Shared geometry and state encoding for the Hack screen read path.
// The screen is 512x256 one-bit pixels stored as 32 sixteen-bit words per row.
package hack_screen_pkg;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int SCREEN_ADDR_W = 13;

  typedef enum logic {
    IDLE = 1'b0,
    LINE = 1'b1
  } scan_state_t;

  function automatic logic [2:0] pick_colour(input logic b, input logic [2:0] fg,
                                             input logic [2:0] bg);
    return b ? fg : bg;
  endfunction

endpackage

// File: rtl/pixel_shifter16.sv
// 16-bit right-shifting word register; bit0 is the next pixel to be shown.
// Load wins over shift, and shift wins over clear.
module pixel_shifter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [15:0] din,
  output logic        bit0
);

  logic [15:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {1'b0, q[15:1]};
    end else if (clear) begin
      q <= '0;
    end
  end

  assign bit0 = q[0];

endmodule

// File: rtl/hack_screen_scanner.sv
// Fetches Hack screen words in raster order and serializes them into 3-bit pixels,
// one pixel per clk, one clk behind the hvsync_generator counters.
module hack_screen_scanner
  import hack_screen_pkg::*;
#(
  parameter int unsigned H_ORIGIN = 64,
  parameter int unsigned V_ORIGIN = 112,
  parameter logic [2:0]  FG_COLOR = 3'b111,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               counter_x,
  input  logic [9:0]               counter_y,
  input  logic                     in_display_area,
  output logic [SCREEN_ADDR_W-1:0] mem_addr,
  output logic                     mem_rd_en,
  input  logic [15:0]              mem_rdata,
  output logic [2:0]               pixel,
  output logic                     in_window
);

  localparam logic [9:0] H0     = 10'(H_ORIGIN);
  localparam logic [9:0] V0     = 10'(V_ORIGIN);
  localparam logic [9:0] FETCH0 = 10'(H_ORIGIN - 2);

  scan_state_t state, state_nxt;
  logic [9:0]  dx, dy, fx;
  logic        in_rows, in_cols, win, fetch_slot, fetch;
  logic [4:0]  fetch_k;
  logic [7:0]  row;
  logic        rd_q, live, step, have, data_bit;
  logic        sh_load, sh_shift, sh_clear, sh_bit0;
  logic [9:0]  prev_x;
  logic [2:0]  pixel_nxt;

  assign dx = counter_x - H0;
  assign dy = counter_y - V0;
  assign fx = counter_x - FETCH0;

  assign in_rows    = (counter_y >= V0) && (dy < 10'(SCREEN_H));
  assign in_cols    = (counter_x >= H0) && (dx < 10'(SCREEN_W));
  assign win        = in_rows && in_cols;
  assign row        = dy[7:0];
  // Fetch slots sit two clocks ahead of each word's first column (sync-read RAM).
  assign fetch_slot = (counter_x >= FETCH0) && (fx[3:0] == 4'd0) && (fx < 10'(SCREEN_W));
  assign fetch_k    = fx[8:4];
  assign step       = (counter_x == prev_x + 10'd1);

  // The fetch for word 0 is issued in the same cycle that opens the line.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      IDLE: begin
        if (in_rows && fetch_slot && fetch_k == 5'd0) begin
          fetch     = 1'b1;
          state_nxt = LINE;
        end
      end
      LINE: begin
        if (!in_rows) begin
          state_nxt = IDLE;
        end else if (fetch_slot) begin
          fetch = 1'b1;
          if (fetch_k == 5'(WORDS_PER_ROW - 1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A broken counter sequence drops the word in flight; output stays BG until a fresh load.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_clear = 1'b0;
    have     = 1'b0;
    data_bit = 1'b0;
    if (win && dx[3:0] == 4'd0 && rd_q) begin
      sh_load  = 1'b1;
      have     = 1'b1;
      data_bit = mem_rdata[0];
    end else if (win && live && step && dx[3:0] != 4'd0) begin
      sh_shift = 1'b1;
      have     = 1'b1;
      data_bit = sh_bit0;
    end else begin
      sh_clear = 1'b1;
    end
  end

  always_comb begin
    pixel_nxt = 3'b000;
    if (in_display_area) begin
      pixel_nxt = win ? pick_colour(have && data_bit, FG_COLOR, BG_COLOR) : BG_COLOR;
    end
  end

  pixel_shifter16 u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sh_clear),
    .load  (sh_load),
    .shift (sh_shift),
    .din   ({1'b0, mem_rdata[15:1]}),
    .bit0  (sh_bit0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      rd_q      <= 1'b0;
      live      <= 1'b0;
      prev_x    <= '0;
      pixel     <= 3'b000;
      in_window <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_rd_en <= fetch;
      if (fetch) mem_addr <= {row, fetch_k};
      rd_q      <= mem_rd_en;
      live      <= have;
      prev_x    <= counter_x;
      pixel     <= pixel_nxt;
      in_window <= win && in_display_area;
    end
  end

endmodule
